iterative_shifter: RTL and testbench

Multi-cycle shift/rotate unit for the execution core. It replaces single-step shift handling with a count-driven iterative engine: one bit position per cycle, WIDTH-parametrised, with a narrow (half-width) mode. It computes x86 shift/rotate results and flags (CF, OF, SF, ZF, PF) for the microcode sequencer.

---
 rtl/iterative_shifter_pkg.sv | 22 ++
 rtl/iterative_shifter_step.sv | 29 ++
 rtl/iterative_shifter.sv | 90 +++++++++
 tb/tb_iterative_shifter.sv | 98 +++++++++
 4 files changed

// File: rtl/iterative_shifter_pkg.sv
// iterative_shifter_pkg: shift op encoding, FSM states and flag bit positions
package iterative_shifter_pkg;
   typedef enum logic [2:0] {
      OP_SHL = 3'd0,
      OP_SHR = 3'd1,
      OP_SAR = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4,
      OP_RCL = 3'd5,
      OP_RCR = 3'd6,
      OP_RSV = 3'd7
   } shift_op_e;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   localparam int CF_IDX = 0;
   localparam int PF_IDX = 2;
   localparam int AF_IDX = 4;
   localparam int ZF_IDX = 6;
   localparam int SF_IDX = 7;
   localparam int OF_IDX = 11;
endpackage

// File: rtl/iterative_shifter_step.sv
// shift_step: one-bit shift/rotate of the working field and carry
module shift_step
   import iterative_shifter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]       op,
   input  logic             is_narrow,
   input  logic [WIDTH-1:0] v,
   input  logic             c,
   output logic [WIDTH-1:0] v_next,
   output logic             c_next
);
   localparam int H = WIDTH / 2;
   logic msb, lsb, left, in_l, in_r;
   logic [WIDTH-1:0] shl, shr;
   // in narrow mode the upper half rides along untouched
   always_comb begin
      msb    = is_narrow ? v[H-1] : v[WIDTH-1];
      lsb    = v[0];
      left   = op == OP_SHL || op == OP_ROL || op == OP_RCL;
      in_l   = op == OP_ROL ? msb : op == OP_RCL ? c : 1'b0;
      in_r   = op == OP_SAR ? msb : op == OP_ROR ? lsb : op == OP_RCR ? c : 1'b0;
      shl    = is_narrow ? {v[WIDTH-1:H], v[H-2:0], in_l} : {v[WIDTH-2:0], in_l};
      shr    = is_narrow ? {v[WIDTH-1:H], in_r, v[H-1:1]} : {in_r, v[WIDTH-1:1]};
      v_next = op == OP_RSV ? v : left ? shl : shr;
      c_next = op == OP_RSV ? c : left ? msb : lsb;
   end
endmodule

// File: rtl/iterative_shifter.sv
// iterative_shifter: count-driven x86 shift/rotate engine, one bit per cycle,
// producing the result and CF/OF/SF/ZF/PF for the microcode sequencer
module iterative_shifter
   import iterative_shifter_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit MASK_COUNT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             is_narrow,
   input  logic [WIDTH-1:0] a,
   input  logic [7:0]       count,
   input  logic [15:0]      flags_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [15:0]      flags_out
);
   localparam int H = WIDTH / 2;
   state_e state, state_next;
   logic [WIDTH-1:0] v, v_next, field;
   logic c, c_next, narrow_r, msb_old, msb_new, is_shift;
   logic [7:0] rem, n;
   logic [2:0] op_r;
   logic [15:0] flags_r, flags_fin;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op(op_r), .is_narrow(narrow_r), .v(v), .c(c), .v_next(v_next), .c_next(c_next)
   );

   // reserved op collapses to a zero-count pass-through
   always_comb begin
      n = op == OP_RSV ? 8'd0 : MASK_COUNT ? {3'b000, count[4:0]} : count;
      state_next = state == S_IDLE ? (start ? (n == 8'd0 ? S_DONE : S_RUN) : S_IDLE)
                 : state == S_RUN  ? (rem == 8'd1 ? S_DONE : S_RUN)
                 : S_IDLE;
      field     = narrow_r ? (v_next & {{(WIDTH-H){1'b0}}, {H{1'b1}}}) : v_next;
      msb_old   = narrow_r ? v[H-1] : v[WIDTH-1];
      msb_new   = narrow_r ? v_next[H-1] : v_next[WIDTH-1];
      is_shift  = op_r == OP_SHL || op_r == OP_SHR || op_r == OP_SAR;
      flags_fin = flags_r;
      flags_fin[CF_IDX] = c_next;
      flags_fin[OF_IDX] = op_r != OP_SAR && (msb_old ^ msb_new);
      flags_fin[SF_IDX] = is_shift ? msb_new : flags_r[SF_IDX];
      flags_fin[ZF_IDX] = is_shift ? field == '0 : flags_r[ZF_IDX];
      flags_fin[PF_IDX] = is_shift ? ~^field[7:0] : flags_r[PF_IDX];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         v         <= '0;
         c         <= 1'b0;
         rem       <= 8'd0;
         op_r      <= 3'd0;
         narrow_r  <= 1'b0;
         flags_r   <= 16'd0;
         out       <= '0;
         flags_out <= 16'd0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && start) begin
            v        <= a;
            c        <= flags_in[CF_IDX];
            rem      <= n;
            op_r     <= op;
            narrow_r <= is_narrow;
            flags_r  <= flags_in;
            if (n == 8'd0) begin
               out       <= a;
               flags_out <= flags_in;
            end
         end else if (state == S_RUN) begin
            v   <= v_next;
            c   <= c_next;
            rem <= rem - 8'd1;
            if (rem == 8'd1) begin
               out       <= v_next;
               flags_out <= flags_fin;
            end
         end
      end
   end

   assign busy = state != S_IDLE;
   assign done = state == S_DONE;
endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter: directed vectors with hand-computed results for
// the WIDTH=16, MASK_COUNT=1 shifter
module tb_iterative_shifter;
   import iterative_shifter_pkg::*;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, is_narrow = 1'b0;
   logic [2:0] op = 3'd0;
   logic [15:0] a = 16'd0, flags_in = 16'd0, out, flags_out;
   logic [7:0] count = 8'd0;
   logic busy, done;
   int errors = 0, checks = 0;

   iterative_shifter #(.WIDTH(16), .MASK_COUNT(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .is_narrow(is_narrow),
      .a(a), .count(count), .flags_in(flags_in), .busy(busy), .done(done),
      .out(out), .flags_out(flags_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [2:0] o, input logic nar, input logic [15:0] av,
                         input logic [7:0] cnt, input logic [15:0] fi);
      @(posedge clk); #1;
      op = o; is_narrow = nar; a = av; count = cnt; flags_in = fi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat0, input int lat_exp,
                            input logic [15:0] out_exp, input logic [15:0] fl_exp);
      int lat;
      lat = lat0;
      while (!done && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, lat_exp);
      check({tag, "_out"}, out, out_exp);
      check({tag, "_flags"}, flags_out, fl_exp);
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic nar,
                      input logic [15:0] av, input logic [7:0] cnt, input logic [15:0] fi,
                      input int lat_exp, input logic [15:0] out_exp, input logic [15:0] fl_exp);
      launch(o, nar, av, cnt, fi);
      wait_done(tag, 1, lat_exp, out_exp, fl_exp);
   endtask

   initial begin
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out", out, 0);
      check("rst_flags", flags_out, 0);
      #11 reset = 1'b1;

      run("shl",      OP_SHL, 1'b0, 16'h8001, 8'd1,    16'h0000, 2,  16'h0002, 16'h0801);
      run("sar_nar",  OP_SAR, 1'b1, 16'h1280, 8'd3,    16'h0000, 4,  16'h12F0, 16'h0084);
      run("rcl_nar",  OP_RCL, 1'b1, 16'h0001, 8'd9,    16'h0001, 10, 16'h0001, 16'h0801);
      run("ror_mask", OP_ROR, 1'b0, 16'h0001, 8'h21,   16'h0000, 2,  16'h8000, 16'h0801);
      run("cnt20",    OP_ROR, 1'b0, 16'h1234, 8'h20,   16'hABCD, 1,  16'h1234, 16'hABCD);
      run("op7",      OP_RSV, 1'b0, 16'h5A5A, 8'd5,    16'h1234, 1,  16'h5A5A, 16'h1234);
      run("shr_zf",   OP_SHR, 1'b0, 16'h0001, 8'd1,    16'h0000, 2,  16'h0000, 16'h0045);
      run("rol_nar",  OP_ROL, 1'b1, 16'hAB81, 8'd1,    16'h00C4, 2,  16'hAB03, 16'h08C5);

      launch(OP_SHL, 1'b0, 16'h0003, 8'd2, 16'h0000);
      check("busy_run", busy, 1);
      a = 16'hFFFF; count = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("ignore", 2, 3, 16'h000C, 16'h0004);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
      check("out_held", out, 16'h000C);

      launch(OP_SHR, 1'b0, 16'h8000, 8'd10, 16'h0000);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_out", out, 0);
      check("abort_flags", flags_out, 0);
      #2 reset = 1'b1;
      run("shr_after", OP_SHR, 1'b0, 16'h8000, 8'd10, 16'hFFFF, 11, 16'h0020, 16'hF73A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
